// File: rtl/cali_fac_arbiter.sv
// cali_fac_arbiter: shares a two-bank calibration-factor RAM between the calibration datapath and an Avalon-MM host.
// Define CALI_ARB_STATS_EN to build the FRAME_CNT and STALL_CNT statistics counters.
module cali_fac_arbiter #(
    parameter int N_CH = 320,
    parameter int AW   = 9,
    parameter int DW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_sop,
    input  logic          frame_eop,
    input  logic [AW-1:0] dp_address,
    output logic [DW-1:0] dp_readdata,
    output logic          dp_waitrequest,
    input  logic [9:0]    host_address,
    input  logic          host_write,
    input  logic          host_read,
    input  logic [31:0]   host_writedata,
    output logic [31:0]   host_readdata,
    output logic          host_readdatavalid,
    output logic          host_waitrequest,
    output logic [AW:0]   ram_address,
    output logic          ram_wren,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    typedef enum logic [2:0] {IDLE = 3'd0, FRAME = 3'd1, DRAIN = 3'd2, SWAP = 3'd3} state_t;

    state_t state_q, state_d;
    logic drain_q, drain_d, bank_q, bank_d, pending_q, pending_d;
    logic rvalid_q, rvalid_d, rfac_q, rfac_d;
    logic [31:0] rdata_q, rdata_d, reg_rd, frame_cnt, stall_cnt;
    logic dp_own, is_reg, acc, rd, grant, in_range, reg_wr, swap;
    logic unused_ok;

    assign dp_own = (state_q == FRAME) || (state_q == DRAIN);
    assign is_reg = host_address[9];
    assign acc = host_read | host_write;
    assign rd = host_read & ~host_write;
    assign host_waitrequest = acc & ~is_reg & dp_own;
    assign grant = acc & ~host_waitrequest;
    assign in_range = {{(32-AW){1'b0}}, host_address[AW-1:0]} < 32'(N_CH);
    assign reg_wr = grant & host_write & is_reg;
    // A pending commit is applied either in SWAP or on any frame start that is not inside a frame.
    assign swap = pending_q & ((state_q == SWAP) | (frame_sop & (state_q != FRAME)));

    assign dp_waitrequest = 1'b0;
    assign dp_readdata = ram_rdata;
    assign ram_wren = grant & host_write & ~is_reg & in_range;
    assign ram_wdata = host_writedata[DW-1:0];
    assign ram_address = dp_own ? {bank_q, dp_address} :
                         (acc & ~is_reg) ? {~bank_q, host_address[AW-1:0]} : '0;
    assign host_readdatavalid = rvalid_q;
    assign host_readdata = ~rvalid_q ? '0 : rfac_q ? {{(32-DW){1'b0}}, ram_rdata} : rdata_q;
    assign unused_ok = ^host_writedata[31:DW];

    assign reg_rd = (host_address[1:0] == 2'd0) ? {31'b0, pending_q} :
                    (host_address[1:0] == 2'd1) ? {27'b0, state_q, pending_q, bank_q} :
                    (host_address[1:0] == 2'd2) ? frame_cnt : stall_cnt;

    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        case (state_q)
            IDLE:    state_d = frame_sop ? FRAME : IDLE;
            FRAME:   state_d = frame_eop ? DRAIN : FRAME;
            DRAIN: begin
                state_d = frame_sop ? FRAME : !drain_q ? DRAIN : pending_q ? SWAP : IDLE;
                drain_d = ~drain_q;
            end
            SWAP:    state_d = frame_sop ? FRAME : IDLE;
            default: state_d = IDLE;
        endcase
        bank_d = bank_q ^ swap;
        pending_d = (reg_wr & (host_address[1:0] == 2'd0) & host_writedata[0]) | (pending_q & ~swap);
        rvalid_d = grant & rd;
        rfac_d = grant & rd & ~is_reg & in_range;
        rdata_d = (grant & rd & is_reg) ? reg_rd : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            drain_q   <= 1'b0;
            bank_q    <= 1'b0;
            pending_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rfac_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            bank_q    <= bank_d;
            pending_q <= pending_d;
            rvalid_q  <= rvalid_d;
            rfac_q    <= rfac_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef CALI_ARB_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        frame_cnt_d = (reg_wr && host_address[1:0] == 2'd2) ? '0 : frame_cnt_q + {31'b0, frame_sop};
        stall_cnt_d = (reg_wr && host_address[1:0] == 2'd3) ? '0 :
                      stall_cnt_q + {31'b0, host_waitrequest & ~&stall_cnt_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign frame_cnt = '0;
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_cali_fac_arbiter.sv
// tb_cali_fac_arbiter: directed and randomized checks of cali_fac_arbiter against a bank-level reference model.
module tb_cali_fac_arbiter;
    localparam int N_CH = 320;
    localparam int S_IDLE = 0, S_FRAME = 1, S_DRAIN = 2, S_SWAP = 3;
`ifdef CALI_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, frame_sop, frame_eop, host_write, host_read;
    logic ram_wren, host_readdatavalid, host_waitrequest, dp_waitrequest;
    logic [8:0] dp_address;
    logic [15:0] dp_readdata, ram_wdata, ram_rdata;
    logic [9:0] host_address, ram_address;
    logic [31:0] host_writedata, host_readdata;

    cali_fac_arbiter #(.N_CH(N_CH), .AW(9), .DW(16)) dut (
        .clk(clk), .rst(rst), .frame_sop(frame_sop), .frame_eop(frame_eop),
        .dp_address(dp_address), .dp_readdata(dp_readdata), .dp_waitrequest(dp_waitrequest),
        .host_address(host_address), .host_write(host_write), .host_read(host_read),
        .host_writedata(host_writedata), .host_readdata(host_readdata),
        .host_readdatavalid(host_readdatavalid), .host_waitrequest(host_waitrequest),
        .ram_address(ram_address), .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 40503 + 4660);
    endfunction

    // Factor RAM: single port, one cycle read latency, address {bank, index}.
    logic [15:0] ram [1024];
    logic ram_init;
    always @(posedge clk) begin
        if (ram_init) for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
        else if (ram_wren) ram[ram_address] <= ram_wdata;
        ram_rdata <= ram[ram_address];
    end

    int checks = 0, errors = 0;
    int m_st, m_dc, fr_left, fr_len, dp_force, n;
    bit m_bank, m_pend, prev_own, exp_rv, obs_gnt, sop_req, saw_swap;
    logic [15:0] exp_dp;
    logic [31:0] exp_rd, rd_obs, m_frames, m_stalls;
    logic [15:0] ref_mem [2][N_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_st = S_IDLE; m_dc = 0; m_bank = 0; m_pend = 0;
        prev_own = 0; exp_rv = 0; m_frames = 0; m_stalls = 0;
    endtask

    // One clock: drive datapath, check DUT at negedge against the model, advance the model.
    task automatic cyc();
        logic [8:0] idx;
        logic [31:0] rv;
        bit acc, fac, own, grant, rd, wr, inr, swap, set, clr_f, clr_s;
        frame_sop = sop_req;
        frame_eop = 1'b0;
        if (sop_req) begin
            fr_left = fr_len;
            sop_req = 0;
        end else if (fr_left > 0) begin
            fr_left--;
            frame_eop = (fr_left == 0);
        end
        dp_address = dp_force >= 0 ? 9'(dp_force) : 9'($urandom_range(0, N_CH - 1));
        @(negedge clk);
        idx = host_address[8:0];
        wr = host_write;
        rd = host_read && !host_write;
        acc = wr || rd;
        fac = acc && !host_address[9];
        own = (m_st == S_FRAME) || (m_st == S_DRAIN);
        inr = int'(idx) < N_CH;
        grant = acc && !(fac && own);
        obs_gnt = acc && !host_waitrequest;
        chk("waitrequest", 32'(host_waitrequest), 32'(fac && own));
        chk("dp_waitrequest", 32'(dp_waitrequest), 32'd0);
        chk("ram_wren", 32'(ram_wren), 32'(grant && wr && fac && inr));
        if (own) chk("ram_addr_dp", 32'(ram_address), 32'({m_bank, dp_address}));
        else if (fac) chk("ram_addr_host", 32'(ram_address), 32'({!m_bank, idx}));
        if (grant && wr && fac && inr) chk("ram_wdata", 32'(ram_wdata), 32'(host_writedata[15:0]));
        if (prev_own) chk("dp_readdata", 32'(dp_readdata), 32'(exp_dp));
        chk("readdatavalid", 32'(host_readdatavalid), 32'(exp_rv));
        if (exp_rv) chk("readdata", host_readdata, exp_rd);
        if (host_readdatavalid) rd_obs = host_readdata;
        prev_own = own;
        exp_dp = ref_mem[m_bank][dp_address];
        exp_rv = grant && rd;
        case (host_address[1:0])
            2'd0: rv = {31'b0, m_pend};
            2'd1: rv = {27'b0, 3'(m_st), m_pend, m_bank};
            2'd2: rv = m_frames;
            default: rv = m_stalls;
        endcase
        exp_rd = 0;
        if (host_address[9]) exp_rd = rv;
        else if (inr) exp_rd = {16'b0, ref_mem[!m_bank][idx]};
        if (grant && wr && fac && inr) ref_mem[!m_bank][idx] = host_writedata[15:0];
        set = grant && wr && host_address[9] && host_address[1:0] == 2'd0 && host_writedata[0];
        clr_f = grant && wr && host_address[9] && host_address[1:0] == 2'd2;
        clr_s = grant && wr && host_address[9] && host_address[1:0] == 2'd3;
        swap = m_pend && (m_st == S_SWAP || (frame_sop && m_st != S_FRAME));
        if (STATS) begin
            m_frames = clr_f ? 0 : m_frames + 32'(frame_sop);
            if (clr_s) m_stalls = 0;
            else if (fac && own && m_stalls != 32'hFFFF_FFFF) m_stalls++;
        end
        if (frame_sop && m_st != S_FRAME) m_st = S_FRAME;
        else if (m_st == S_FRAME && frame_eop) begin m_st = S_DRAIN; m_dc = 0; end
        else if (m_st == S_DRAIN) begin
            if (m_dc == 1) m_st = m_pend ? S_SWAP : S_IDLE;
            else m_dc = 1;
        end else if (m_st == S_SWAP) m_st = S_IDLE;
        m_bank = m_bank ^ swap;
        m_pend = set || (m_pend && !swap);
        @(posedge clk);
        #1;
    endtask

    task automatic host_op(input bit w, input logic [9:0] a, input logic [31:0] d, output int stalls);
        host_write = w; host_read = !w; host_address = a; host_writedata = d;
        stalls = 0;
        obs_gnt = 0;
        for (int i = 0; i < 64 && !obs_gnt; i++) begin
            cyc();
            if (!obs_gnt) stalls++;
        end
        chk("grant_in_budget", 32'(obs_gnt), 32'd1);
        host_write = 0; host_read = 0;
        if (!w) cyc();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && (m_st != S_IDLE || fr_left != 0); i++) cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; ram_init = 1; frame_sop = 0; frame_eop = 0; dp_address = 0;
        host_address = 0; host_write = 0; host_read = 0; host_writedata = 0;
        fr_left = 0; fr_len = 0; sop_req = 0; dp_force = -1; rd_obs = 0;
        for (int b = 0; b < 2; b++) for (int i = 0; i < N_CH; i++) ref_mem[b][i] = pat(b * 512 + i);
        reset_model();
        repeat (2) @(posedge clk);
        #1 ram_init = 0;
        @(negedge clk);
        chk("rst_readdatavalid", 32'(host_readdatavalid), 32'd0);
        chk("rst_readdata", host_readdata, 32'd0);
        chk("rst_wren", 32'(ram_wren), 32'd0);
        chk("rst_ram_address", 32'(ram_address), 32'd0);
        @(posedge clk);
        #1 rst = 0;
        host_op(0, 10'h201, 0, n);
        chk("rst_status", rd_obs, 32'd0);

        // Load the shadow bank with no frame running.
        host_op(1, 10'd5, 32'hABCD_1234, n);
        chk("load_no_stall", 32'(n), 32'd0);
        host_op(0, 10'd5, 0, n);
        chk("load_readback", rd_obs, 32'h0000_1234);

        // Commit in IDLE: swap lands on the frame start.
        host_op(1, 10'h200, 32'd1, n);
        fr_len = 6; sop_req = 1; cyc();
        dp_force = 5; cyc(); dp_force = -1;
        chk("commit_dp_factor", 32'(dp_readdata), 32'h1234);
        wait_idle();
        host_op(0, 10'h201, 0, n);
        chk("commit_status", rd_obs, 32'h1);

        // Commit mid-frame: deferred until after the drain.
        fr_len = 12; sop_req = 1; cyc();
        repeat (3) cyc();
        host_op(1, 10'h200, 32'd1, n);
        host_op(0, 10'h201, 0, n);
        chk("defer_mid_status", rd_obs, 32'h7);
        saw_swap = 0;
        host_read = 1; host_address = 10'h201;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (rd_obs[4:2] == 3'd3) saw_swap = 1;
            if (saw_swap && rd_obs[4:2] == 3'd0) break;
        end
        host_read = 0; cyc();
        chk("defer_swap_seen", 32'(saw_swap), 32'd1);
        chk("defer_status_after", rd_obs, 32'h0);

        // Host stall across a frame.
        host_op(1, 10'h203, 0, n);
        fr_len = 8; sop_req = 1; cyc();
        host_op(1, 10'd7, 32'h5555_BEEF, n);
        chk("stall_cycles", 32'(n), 32'd10);
        host_op(0, 10'h203, 0, n);
        chk("stall_cnt", rd_obs, STATS ? 32'd10 : 32'd0);
        host_op(0, 10'd7, 0, n);
        chk("stall_write_data", rd_obs, 32'h0000_BEEF);

        // Out-of-range index and frame start on the last drain cycle.
        host_op(1, 10'd320, 32'h0000_FFFF, n);
        chk("oor_write_no_stall", 32'(n), 32'd0);
        host_op(0, 10'd320, 0, n);
        chk("oor_read_zero", rd_obs, 32'd0);
        fr_len = 4; sop_req = 1; cyc();
        host_op(1, 10'h200, 32'd1, n);
        for (int i = 0; i < 30 && !(m_st == S_DRAIN && m_dc == 1); i++) cyc();
        fr_len = 4; sop_req = 1; cyc();
        host_op(0, 10'h201, 0, n);
        chk("drain_sop_swap", rd_obs, 32'h5);
        wait_idle();

        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2 && fr_left == 0) begin
                fr_len = int'($urandom_range(1, 10)); sop_req = 1; cyc();
            end else if (r < 5) host_op(1, {1'b0, 9'($urandom_range(0, 330))}, $urandom, n);
            else if (r < 8) host_op(0, {1'b0, 9'($urandom_range(0, 330))}, 0, n);
            else if (r == 8) host_op(1'($urandom_range(0, 1)), {8'h80, 2'($urandom_range(0, 3))}, $urandom, n);
            else cyc();
        end
        wait_idle();

        // Reset in the middle of a frame with a commit pending.
        fr_len = 20; sop_req = 1; cyc();
        host_op(1, 10'h200, 32'd1, n);
        repeat (3) cyc();
        rst = 1;
        #1;
        chk("rst2_readdatavalid", 32'(host_readdatavalid), 32'd0);
        chk("rst2_readdata", host_readdata, 32'd0);
        chk("rst2_wren", 32'(ram_wren), 32'd0);
        chk("rst2_ram_address", 32'(ram_address), 32'd0);
        chk("rst2_waitrequest", 32'(host_waitrequest), 32'd0);
        frame_sop = 0; frame_eop = 0; fr_left = 0; sop_req = 0;
        @(posedge clk);
        #1 rst = 0;
        reset_model();
        host_op(0, 10'h201, 0, n);
        chk("rst2_status", rd_obs, 32'd0);
        host_op(0, 10'h202, 0, n);
        chk("rst2_frame_cnt", rd_obs, 32'd0);
        fr_len = 5; sop_req = 1; cyc();
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
